// File: rtl/poseidon_stream_bfm_if.sv
// Stream bundle between the packet driver/collector and the Poseidon core.
// m_* carries input words to the core, s_* carries results back.
interface poseidon_stream_bfm_if #(
    parameter int DATA_W = 255
);
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [DATA_W-1:0] m_payload;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [DATA_W-1:0] s_payload;

    // Driver side: sources the word stream, sinks the result stream.
    modport master (
        output m_valid, m_last, m_payload, s_ready,
        input  m_ready, s_valid, s_last, s_payload
    );

    // Core side: sinks the word stream, sources the result stream.
    modport slave (
        input  m_valid, m_last, m_payload, s_ready,
        output m_ready, s_valid, s_last, s_payload
    );
endinterface

// File: rtl/poseidon_stream_bfm.sv
// Packet driver/collector for the Poseidon hash core. The host preloads words,
// then a start streams cfg_num_pkts packets of ELEMS words each to the core and
// collects one single-beat result per packet, with optional inter-packet gap
// and timeout/protocol error reporting.
module poseidon_stream_bfm #(
    parameter int DATA_W   = 255,
    parameter int ELEMS    = 3,
    parameter int MAX_PKTS = 128,
    parameter int GAP_W    = 8,
    parameter int TIMEOUT  = 1024,
    localparam int CNT_W   = $clog2(MAX_PKTS + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic                 ld_clr,
    input  logic [CNT_W-1:0]     cfg_num_pkts,
    input  logic [GAP_W-1:0]     cfg_gap,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    poseidon_stream_bfm_if.master strm,
    output logic                 res_valid,
    output logic [DATA_W-1:0]    res_data,
    output logic [CNT_W-1:0]     tx_pkt_cnt,
    output logic [CNT_W-1:0]     rx_cnt,
    output logic                 err_cfg,
    output logic                 err_last,
    output logic                 err_timeout
);
    localparam int DEPTH = MAX_PKTS * ELEMS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int EW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [EW-1:0]     elem_idx;
    logic [CNT_W-1:0]  num_q;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TW-1:0]     idle_cnt;

    logic ld_hs, m_hs, s_hs;
    logic is_last_elem, pkt_final;
    logic cfg_ok, start_ok, start_bad;
    logic rx_done, timeout_hit;

    assign ld_hs        = ld_valid && ld_ready;
    assign m_hs         = strm.m_valid && strm.m_ready;
    assign s_hs         = strm.s_valid && strm.s_ready;
    assign is_last_elem = (elem_idx == EW'(ELEMS - 1));
    assign pkt_final    = ((tx_pkt_cnt + CNT_W'(1)) == num_q);

    // Capacity check uses wr_ptr as it stood before any write in this cycle.
    assign cfg_ok    = (cfg_num_pkts != '0)
                    && (32'(cfg_num_pkts) <= 32'(MAX_PKTS))
                    && ((32'(cfg_num_pkts) * 32'(ELEMS)) <= 32'(wr_ptr));
    assign start_ok  = (state == ST_IDLE) && start && cfg_ok;
    assign start_bad = (state == ST_IDLE) && start && !cfg_ok;

    // A result accepted this very cycle counts toward completion.
    assign rx_done     = (rx_cnt == num_q) || (s_hs && ((rx_cnt + CNT_W'(1)) == num_q));
    assign timeout_hit = !s_hs && (idle_cnt == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode and stream/status outputs.
    always_comb begin
        state_nxt      = state;
        ld_ready       = 1'b0;
        busy           = (state != ST_IDLE);
        done           = 1'b0;
        strm.m_valid   = 1'b0;
        strm.m_last    = 1'b0;
        strm.m_payload = '0;
        strm.s_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                ld_ready = (wr_ptr < PTR_W'(DEPTH));
                if (start_ok) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                strm.m_valid   = 1'b1;
                strm.m_last    = is_last_elem;
                strm.m_payload = mem[rd_ptr[AW-1:0]];
                strm.s_ready   = 1'b1;
                if (m_hs && is_last_elem) begin
                    if (pkt_final)          state_nxt = ST_DRAIN;
                    else if (gap_q != '0)   state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                strm.s_ready = 1'b1;
                if (gap_cnt == GAP_W'(1)) state_nxt = ST_SEND;
            end
            ST_DRAIN: begin
                strm.s_ready = 1'b1;
                if (rx_done || timeout_hit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Host load pointer; clear wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (!resetn)                           wr_ptr <= '0;
        else if ((state == ST_IDLE) && ld_clr) wr_ptr <= '0;
        else if (ld_hs)                        wr_ptr <= wr_ptr + PTR_W'(1);
    end

    // Word buffer, intentionally not reset.
    always_ff @(posedge clk) begin
        if (ld_hs && !ld_clr) mem[wr_ptr[AW-1:0]] <= ld_data;
    end

    // Run datapath: read pointer, packet/result counters, gap and idle timers, sticky errors.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr      <= '0;
            elem_idx    <= '0;
            tx_pkt_cnt  <= '0;
            rx_cnt      <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            idle_cnt    <= '0;
            err_last    <= 1'b0;
            err_timeout <= 1'b0;
        end else if (start_ok) begin
            rd_ptr      <= '0;
            elem_idx    <= '0;
            tx_pkt_cnt  <= '0;
            rx_cnt      <= '0;
            num_q       <= cfg_num_pkts;
            gap_q       <= cfg_gap;
            idle_cnt    <= '0;
            err_last    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (m_hs) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                elem_idx <= is_last_elem ? '0 : elem_idx + EW'(1);
                if (is_last_elem) begin
                    tx_pkt_cnt <= tx_pkt_cnt + CNT_W'(1);
                    gap_cnt    <= gap_q;
                end
            end
            if (state == ST_GAP) gap_cnt <= gap_cnt - GAP_W'(1);
            if (s_hs) begin
                rx_cnt   <= rx_cnt + CNT_W'(1);
                idle_cnt <= '0;
                if (!strm.s_last) err_last <= 1'b1;
            end else if (state == ST_DRAIN) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
            if ((state == ST_DRAIN) && !rx_done && timeout_hit) err_timeout <= 1'b1;
        end
    end

    // Registered result copy and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            err_cfg   <= 1'b0;
        end else begin
            res_valid <= s_hs;
            if (s_hs) res_data <= strm.s_payload;
            err_cfg   <= start_bad;
        end
    end
endmodule

// File: tb/tb_poseidon_stream_bfm.sv
// Randomized bench for poseidon_stream_bfm: a core model answers each packet
// with the sum of its words, and a queue-based reference of the load buffer
// predicts beat order, last flags, gaps, results and counters.
module tb_poseidon_stream_bfm;
    localparam int DW    = 32;
    localparam int EL    = 3;
    localparam int MP    = 8;
    localparam int GW    = 8;
    localparam int TO    = 40;
    localparam int CW    = $clog2(MP + 1);
    localparam int DEPTH = MP * EL;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ld_valid, ld_ready, ld_clr;
    logic [DW-1:0] ld_data;
    logic [CW-1:0] cfg_num_pkts;
    logic [GW-1:0] cfg_gap;
    logic          start, busy, done;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [CW-1:0] tx_pkt_cnt, rx_cnt;
    logic          err_cfg, err_last, err_timeout;

    poseidon_stream_bfm_if #(.DATA_W(DW)) bus ();

    poseidon_stream_bfm #(
        .DATA_W(DW), .ELEMS(EL), .MAX_PKTS(MP), .GAP_W(GW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_clr(ld_clr),
        .cfg_num_pkts(cfg_num_pkts), .cfg_gap(cfg_gap), .start(start),
        .busy(busy), .done(done), .strm(bus),
        .res_valid(res_valid), .res_data(res_data),
        .tx_pkt_cnt(tx_pkt_cnt), .rx_cnt(rx_cnt),
        .err_cfg(err_cfg), .err_last(err_last), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0;
    int miscnt  = 0;

    // Reference model of the load buffer.
    logic [DW-1:0] model_buf [DEPTH];
    int            model_wr = 0;

    // Core-model configuration (written by the main sequence only).
    int ready_mode = 0, res_delay = 0, res_limit = 1000, run_id = 0;
    bit res_bad_first = 1'b0;

    // Observation logs (written by the core model only).
    logic [DW-1:0] beat_pay [$];
    bit            beat_last [$];
    int            beat_cyc [$];
    logic [DW-1:0] res_seen [$];
    logic [DW-1:0] pend_pay [$];
    int            pend_due [$];
    int            stall_viol = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Core model: drives m_ready and returns one result per observed packet.
    initial begin
        logic [DW-1:0] acc, prev_pay;
        bit            prev_stall, prev_last, s_hs;
        int            sent, seen_run, phase;
        acc = '0; prev_pay = '0; prev_stall = 0; prev_last = 0;
        sent = 0; seen_run = 0; phase = 0;
        bus.m_ready = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_payload = '0;
        forever begin
            @(negedge clk);
            if (run_id != seen_run) begin
                seen_run = run_id; sent = 0; acc = '0;
            end
            s_hs = bus.s_valid && bus.s_ready;
            if (!resetn) begin
                pend_pay.delete(); pend_due.delete(); acc = '0;
            end else begin
                if (prev_stall && (!bus.m_valid || bus.m_payload !== prev_pay || bus.m_last !== prev_last))
                    stall_viol++;
                if (bus.m_valid && bus.m_ready) begin
                    beat_pay.push_back(bus.m_payload);
                    beat_last.push_back(bus.m_last);
                    beat_cyc.push_back(cyc);
                    acc = acc + bus.m_payload;
                    if (bus.m_last) begin
                        if (sent < res_limit) begin
                            pend_pay.push_back(acc);
                            pend_due.push_back(cyc + res_delay);
                            sent++;
                        end
                        acc = '0;
                    end
                end
                if (res_valid) res_seen.push_back(res_data);
            end
            prev_stall = resetn && bus.m_valid && !bus.m_ready;
            prev_pay   = bus.m_payload;
            prev_last  = bus.m_last;
            @(posedge clk);
            #1;
            if (s_hs || !resetn) bus.s_valid = 1'b0;
            if (s_hs && pend_pay.size() > 0) begin
                void'(pend_pay.pop_front());
                void'(pend_due.pop_front());
            end
            phase++;
            case (ready_mode)
                1:       bus.m_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
                2:       bus.m_ready = ($urandom_range(0, 3) != 0);
                default: bus.m_ready = 1'b1;
            endcase
            if (!bus.s_valid && pend_pay.size() > 0 && pend_due[0] <= cyc) begin
                bus.s_valid   = 1'b1;
                bus.s_payload = pend_pay[0];
                bus.s_last    = !(res_bad_first && (sent - pend_pay.size()) == 0);
            end
        end
    end

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ld_valid = 1'b1;
            ld_data  = $urandom;
            @(negedge clk);
            check_eq("ld_ready", ld_ready, 64'(model_wr < DEPTH));
            if (model_wr < DEPTH) begin
                model_buf[model_wr] = ld_data;
                model_wr++;
            end
        end
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    // Clear with a simultaneous write attempt; the write must be discarded.
    task automatic clear_buf();
        @(posedge clk); #1;
        ld_clr = 1'b1; ld_valid = 1'b1; ld_data = $urandom;
        @(posedge clk); #1;
        ld_clr = 1'b0; ld_valid = 1'b0;
        model_wr = 0;
    endtask

    task automatic start_expect_reject(input int num);
        bit exp_rej;
        exp_rej = !(num >= 1 && num <= MP && num * EL <= model_wr);
        @(posedge clk); #1;
        cfg_num_pkts = CW'(num); cfg_gap = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("err_cfg_pulse", err_cfg, 64'(exp_rej));
        check_eq("reject_busy", busy, 64'(!exp_rej));
        @(negedge clk);
        check_eq("reject_m_valid", bus.m_valid, 64'(!exp_rej));
        @(posedge clk); #1;
        check_eq("err_cfg_clear", err_cfg, 0);
    endtask

    task automatic run_pkts(input int num, input int gap, input int mode, input int dly,
                            input int limit, input bit badlast);
        int b0, r0, sv0, nb, nr, nexp, done_cyc, d, dexp;
        bit got;
        logic [DW-1:0] esum;
        ready_mode = mode; res_delay = dly; res_limit = limit; res_bad_first = badlast;
        run_id++;
        @(posedge clk); #1;
        b0 = beat_pay.size(); r0 = res_seen.size(); sv0 = stall_viol;
        cfg_num_pkts = CW'(num); cfg_gap = GW'(gap); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_on_start", busy, 1);
        got = 0; done_cyc = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1; done_cyc = cyc;
            end
        end
        check_eq("done_reached", 64'(got), 1);
        if (got) begin
            nexp = (limit < num) ? limit : num;
            check_eq("tx_pkt_cnt", tx_pkt_cnt, 64'(num));
            check_eq("rx_cnt", rx_cnt, 64'(nexp));
            check_eq("err_last", err_last, 64'(badlast && nexp > 0));
            check_eq("err_timeout", err_timeout, 64'(limit < num));
            @(negedge clk);
            check_eq("done_one_cycle", done, 0);
            check_eq("idle_after_done", busy, 0);
            nb = beat_pay.size() - b0;
            check_eq("beat_cnt", 64'(nb), 64'(num * EL));
            for (int i = 0; i < nb && i < num * EL; i++) begin
                check_eq("beat_payload", beat_pay[b0 + i], model_buf[i]);
                check_eq("beat_last", 64'(beat_last[b0 + i]), 64'((i % EL) == EL - 1));
                if (mode == 0 && i > 0) begin
                    d    = beat_cyc[b0 + i] - beat_cyc[b0 + i - 1];
                    dexp = ((i % EL) == 0) ? gap + 1 : 1;
                    check_eq("beat_spacing", 64'(d), 64'(dexp));
                end
            end
            nr = res_seen.size() - r0;
            check_eq("res_cnt", 64'(nr), 64'(nexp));
            for (int p = 0; p < nr && p < nexp; p++) begin
                esum = '0;
                for (int e = 0; e < EL; e++) esum = esum + model_buf[p * EL + e];
                check_eq("res_data", res_seen[r0 + p], esum);
            end
            if (limit < num && nb > 0)
                check_eq("timeout_len", 64'(done_cyc - beat_cyc[b0 + nb - 1]), 64'(TO + 1));
            check_eq("stall_stable", 64'(stall_viol - sv0), 0);
        end
    endtask

    task automatic reset_mid_send();
        int b0;
        bit seen;
        ready_mode = 0; res_delay = 2; res_limit = 1000; res_bad_first = 0;
        run_id++;
        @(posedge clk); #1;
        b0 = beat_pay.size();
        cfg_num_pkts = CW'(2); cfg_gap = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (beat_pay.size() - b0 >= 2) seen = 1;
        end
        check_eq("two_beats_before_reset", 64'(seen), 1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_m_valid", bus.m_valid, 0);
        check_eq("rst_s_ready", bus.s_ready, 0);
        check_eq("rst_tx_cnt", tx_pkt_cnt, 0);
        check_eq("rst_rx_cnt", rx_cnt, 0);
        check_eq("rst_ld_ready", ld_ready, 1);
        resetn = 1'b1;
        model_wr = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec_cnt);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; ld_valid = 1'b0; ld_clr = 1'b0; ld_data = '0;
        cfg_num_pkts = '0; cfg_gap = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_m_valid", bus.m_valid, 0);
        check_eq("reset_s_ready", bus.s_ready, 0);
        check_eq("reset_res_valid", res_valid, 0);
        check_eq("reset_counts", {tx_pkt_cnt, rx_cnt}, 0);
        check_eq("reset_errs", {err_cfg, err_last, err_timeout}, 0);
        check_eq("reset_ld_ready", ld_ready, 1);
        resetn = 1'b1;

        // Basic two-packet run, back-to-back, always ready.
        load_words(6);
        run_pkts(2, 0, 0, 2, 1000, 0);
        // Rerun without reload under a 1,0,0,1 ready pattern.
        run_pkts(2, 0, 1, 3, 1000, 0);
        // Inter-packet gap of 4.
        clear_buf();
        load_words(9);
        run_pkts(3, 4, 0, 1, 1000, 0);
        // Rejected starts: too many packets for the loaded words, zero, above MAX_PKTS.
        clear_buf();
        load_words(6);
        start_expect_reject(3);
        start_expect_reject(0);
        start_expect_reject(MP + 1);
        // Bad last flag followed by a missing result.
        run_pkts(2, 0, 0, 1, 1, 1);
        // Sticky errors clear on the next accepted start.
        run_pkts(1, 0, 0, 0, 1000, 0);
        // Full buffer, random gap, ready and result latency.
        clear_buf();
        load_words(DEPTH + 1);
        run_pkts(MP, $urandom_range(0, 3), 2, $urandom_range(0, 4), 1000, 0);
        run_pkts($urandom_range(1, MP), $urandom_range(0, 2), 2, $urandom_range(0, 3), 1000, 0);
        // Reset in the middle of streaming.
        reset_mid_send();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscnt);
        $finish;
    end
endmodule
